fp_addsub_issue: RTL and testbench
==================================

// Module: fp_addsub_issue
// PURPOSE
// - Pipelined issue/retire stage wrapped around the FP32 add/sub datapath (add_sub_top).
// - Accepts packed IEEE-754 single operands plus an opcode over valid/ready.
// - Registers and unpacks operands into sign/exp/sig, feeds add_sub_top, and registers fp_out/error.
// - Accumulates sticky error flags for the FPU control/status logic.
// PARAMETERS
// - TAG_W    default 4   width of opaque tag carried alongside each op (ROB/dest id)
// PORTS
// - clk        in   1       clock; all state rises on posedge
// - reset      in   1       asynchronous, active-high reset
// - in_valid   in   1       operand bundle valid
// - in_ready   out  1       stage can accept bundle this cycle
// - in_a       in   32      operand 1, packed FP32 {sign,exp[7:0],sig[22:0]}
// - in_b       in   32      operand 2, packed FP32
// - in_op      in   1       0: add (a+b); 1: subtract (a-b)
// - in_tag     in   TAG_W   tag, returned unchanged with result
// - out_valid  out  1       result valid
// - out_ready  in   1       consumer accepts result
// - out_result out  32      registered fp_out of add_sub_top
// - out_error  out  3       registered error of add_sub_top for this op
// - out_tag    out  TAG_W   tag of this result
// - flags      out  3       sticky OR of out_error over retired ops
// - flags_clr  in   1       synchronous clear of flags
// - busy       out  1       any op in flight (a_valid | b_valid)
// BEHAVIOUR
// - Reset (async, any time):
//   - a_valid = b_valid = 0; out_result, out_error, out_tag, flags all 0.
//   - In-flight ops are discarded. No output is produced for them after reset releases.
// - Stage A register: {a, b, op, tag, a_valid}. Stage B register: {result, error, tag, b_valid}.
// - Advance rules:
//   - b_adv = !b_valid | out_ready
//   - a_adv = a_valid & b_adv
//   - in_ready = !a_valid | b_adv (combinational from out_ready; no comb path from in_valid)
// - Accept: in_valid & in_ready loads stage A. Otherwise a_valid clears if a_adv.
// - add_sub_top is driven combinationally from stage A fields: sign1=a[31], exp1=a[30:23], sig1=a[22:0], likewise for b.
// - b_adv loads stage B with {fp_out, error, tag, a_valid}.
// - Latency: bundle accepted at edge N appears with out_valid=1 after edge N+1 (2 registers).
// - Throughput: 1 op/cycle while out_ready=1. Ordering is strictly FIFO; 2 ops max in flight.
// - Backpressure: out_ready=0 with both stages full -> in_ready=0.
//   - Held outputs stay stable while out_valid & !out_ready.
// - Simultaneous accept and advance in the same cycle is legal. Stage A overwrites with no bubble.
// - Retire = out_valid & out_ready.
// - Flags:
//   - retire only: flags <= flags | out_error
//   - flags_clr only: flags <= 0
//   - both in same cycle: flags <= out_error (clear applies to old state; new error is kept)
// - out_valid=0: out_result/out_error/out_tag hold their last value. Consumers ignore them.
// STRUCTURE
// - fpu_pkg (shared):
//   - FP32 field widths (EXP_W=8, SIG_W=23)
//   - typedef struct packed fp32_t {sign, exp, sig}
//   - typedef enum logic fpu_addsub_op_e {FP_ADD=0, FP_SUB=1}
//   - ERR_W=3
// - One sub-module: add_sub_top (existing), instantiated once between stage A and B.
// - Pipeline control stays inline; no further sub-modules.
// TESTING
// - Single add: a=0x3F800000, b=0x40000000, op=0, tag=5.
//   -> out_valid 2 cycles after accept; result=0x40400000, tag=5, error=0.
// - Back-to-back, out_ready=1:
//   - 3.0-1.0 (0x40400000, 0x3F800000, op=1) then 1.5+1.5 (0x3FC00000 x2)
//   - -> results 0x40000000 then 0x40400000 on consecutive cycles, in order.
// - Backpressure: hold out_ready=0, offer 3 ops.
//   - -> 2 accepted, then in_ready=0. Outputs stable.
//   - Release -> 3 results in order; third op accepted the cycle out_ready rises.
// - Sticky flags: a=0x7FC00000 (NaN) + 0x3F800000.
//   - -> out_error!=0 on retire; flags latch it.
//   - Then clean op -> flags unchanged.
//   - flags_clr in the same cycle as a NaN retire -> flags == that op's error only.
// - Reset mid-op: assert reset with both stages full.
//   - -> out_valid=0 and flags=0 immediately (async); busy=0.
//   - No stale result after release.
//   - Next op after release: normal 2-cycle latency.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the FPU add/sub path: field widths, packed operand
// layout, opcode encoding, error bit positions and a leading-zero count helper.
package fpu_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned SIG_W  = 23;
  localparam int unsigned FP_W   = 1 + EXP_W + SIG_W;
  localparam int unsigned ERR_W  = 3;
  // Aligned significand: hidden bit + fraction + guard/round/sticky.
  localparam int unsigned WORK_W = SIG_W + 4;

  localparam int unsigned ERR_INVALID   = 0;
  localparam int unsigned ERR_OVERFLOW  = 1;
  localparam int unsigned ERR_UNDERFLOW = 2;

  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp32_t;

  typedef enum logic {
    FP_ADD = 1'b0,
    FP_SUB = 1'b1
  } fpu_addsub_op_e;

  // Returns WORK_W for an all-zero input.
  function automatic logic [4:0] lzc_work(input logic [WORK_W-1:0] v);
    logic [4:0] n;
    n = 5'(WORK_W);
    for (int unsigned i = 0; i < WORK_W; i++) begin
      if (v[i]) n = 5'(WORK_W - 1 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/add_sub_top.sv
// Combinational FP32 add/sub, round-to-nearest-even, denormals flushed to zero
// on input and output. error = {underflow, overflow, invalid}.
module add_sub_top
  import fpu_pkg::*;
(
  input  logic                 sign1,
  input  logic [EXP_W-1:0]     exp1,
  input  logic [SIG_W-1:0]     sig1,
  input  logic                 sign2,
  input  logic [EXP_W-1:0]     exp2,
  input  logic [SIG_W-1:0]     sig2,
  input  fpu_addsub_op_e       op,
  output logic [FP_W-1:0]      fp_out,
  output logic [ERR_W-1:0]     error
);

  logic              sign2_eff;
  logic              nan1, nan2, inf1, inf2, swap;
  logic [SIG_W:0]    m1, m2, ml, ms;
  logic [EXP_W-1:0]  el, es, d;
  logic              sl, ss;
  logic [WORK_W-1:0] lw, sw_full, sw, norm, diff;
  logic              stk;
  logic [WORK_W:0]   sum;
  logic [4:0]        lz;
  logic [EXP_W:0]    e, e_r;
  logic              uf, inc, r_sign;
  logic [SIG_W+1:0]  rm;
  logic [SIG_W-1:0]  frac;

  // Classify, order by magnitude and align the smaller operand.
  always_comb begin
    sign2_eff = sign2 ^ (op == FP_SUB);
    nan1 = (&exp1) & (|sig1);
    nan2 = (&exp2) & (|sig2);
    inf1 = (&exp1) & ~(|sig1);
    inf2 = (&exp2) & ~(|sig2);
    m1 = (exp1 != '0) ? {1'b1, sig1} : '0;
    m2 = (exp2 != '0) ? {1'b1, sig2} : '0;
    swap = {exp2, m2} > {exp1, m1};
    if (swap) begin
      sl = sign2_eff; el = exp2; ml = m2;
      ss = sign1;     es = exp1; ms = m1;
    end else begin
      sl = sign1;     el = exp1; ml = m1;
      ss = sign2_eff; es = exp2; ms = m2;
    end
    d       = el - es;
    lw      = {ml, 3'b000};
    sw_full = {ms, 3'b000};
    if (d >= 8'(WORK_W)) begin
      sw  = '0;
      stk = |ms;
    end else begin
      sw  = sw_full >> d;
      stk = |(sw_full & ~({WORK_W{1'b1}} << d));
    end
    sw[0] = sw[0] | stk;
  end

  // Add or subtract magnitudes, normalise, round.
  always_comb begin
    sum    = {1'b0, lw} + {1'b0, sw};
    diff   = lw - sw;
    lz     = lzc_work(diff);
    uf     = 1'b0;
    norm   = '0;
    e      = {1'b0, el};
    r_sign = sl;
    if (sl == ss) begin
      if (sum[WORK_W]) begin
        norm = {sum[WORK_W:2], sum[1] | sum[0]};
        e    = {1'b0, el} + 9'd1;
      end else begin
        norm = sum[WORK_W-1:0];
      end
    end else begin
      norm   = diff << lz;
      e      = {1'b0, el} - {4'b0, lz};
      uf     = ({3'b0, lz} >= el) && (diff != '0);
      r_sign = (diff == '0) ? 1'b0 : sl;
    end
    inc  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rm   = {1'b0, norm[WORK_W-1:3]} + {{(SIG_W+1){1'b0}}, inc};
    e_r  = e + {{EXP_W{1'b0}}, rm[SIG_W+1]};
    frac = rm[SIG_W+1] ? rm[SIG_W:1] : rm[SIG_W-1:0];
  end

  always_comb begin
    error  = '0;
    fp_out = {r_sign, e_r[EXP_W-1:0], frac};
    if (nan1 || nan2 || (inf1 && inf2 && (sign1 != sign2_eff))) begin
      fp_out = FP_QNAN;
      error[ERR_INVALID] = 1'b1;
    end else if (inf1) begin
      fp_out = {sign1, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
    end else if (inf2) begin
      fp_out = {sign2_eff, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
    end else if (norm == '0) begin
      fp_out = {r_sign, {(FP_W-1){1'b0}}};
    end else if (uf) begin
      fp_out = {r_sign, {(FP_W-1){1'b0}}};
      error[ERR_UNDERFLOW] = 1'b1;
    end else if (e_r >= {1'b0, {EXP_W{1'b1}}}) begin
      fp_out = {r_sign, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
      error[ERR_OVERFLOW] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_addsub_issue.sv
// Two-register issue/retire wrapper around add_sub_top with valid/ready on both
// sides, an opaque tag per op and sticky error flags.
module fp_addsub_issue
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_a,
  input  logic [FP_W-1:0]  in_b,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_result,
  output logic [ERR_W-1:0] out_error,
  output logic [TAG_W-1:0] out_tag,
  output logic [ERR_W-1:0] flags,
  input  logic             flags_clr,
  output logic             busy
);

  fp32_t            a_q, a_d, b_q, b_d;
  fpu_addsub_op_e   op_q, op_d;
  logic [TAG_W-1:0] tag_a_q, tag_a_d, tag_b_q, tag_b_d;
  logic             a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [FP_W-1:0]  res_q, res_d, sum_res;
  logic [ERR_W-1:0] err_q, err_d, sum_err, flags_q, flags_d;
  logic             a_adv, b_adv, accept, retire;

  add_sub_top u_addsub (
    .sign1  (a_q.sign),
    .exp1   (a_q.exp),
    .sig1   (a_q.sig),
    .sign2  (b_q.sign),
    .exp2   (b_q.exp),
    .sig2   (b_q.sig),
    .op     (op_q),
    .fp_out (sum_res),
    .error  (sum_err)
  );

  always_comb begin
    b_adv    = !b_valid_q || out_ready;
    a_adv    = a_valid_q && b_adv;
    in_ready = !a_valid_q || b_adv;
    accept   = in_valid && in_ready;
    retire   = b_valid_q && out_ready;
  end

  // Stage B data only loads with a real op so the outputs hold across bubbles.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    tag_a_d   = tag_a_q;
    a_valid_d = a_valid_q;
    res_d     = res_q;
    err_d     = err_q;
    tag_b_d   = tag_b_q;
    b_valid_d = b_valid_q;
    flags_d   = flags_q;
    if (accept) begin
      a_d       = fp32_t'(in_a);
      b_d       = fp32_t'(in_b);
      op_d      = fpu_addsub_op_e'(in_op);
      tag_a_d   = in_tag;
      a_valid_d = 1'b1;
    end else if (a_adv) begin
      a_valid_d = 1'b0;
    end
    if (b_adv) begin
      b_valid_d = a_valid_q;
    end
    if (a_adv) begin
      res_d   = sum_res;
      err_d   = sum_err;
      tag_b_d = tag_a_q;
    end
    if (flags_clr) begin
      flags_d = retire ? err_q : '0;
    end else if (retire) begin
      flags_d = flags_q | err_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= FP_ADD;
      tag_a_q   <= '0;
      a_valid_q <= 1'b0;
      res_q     <= '0;
      err_q     <= '0;
      tag_b_q   <= '0;
      b_valid_q <= 1'b0;
      flags_q   <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      tag_a_q   <= tag_a_d;
      a_valid_q <= a_valid_d;
      res_q     <= res_d;
      err_q     <= err_d;
      tag_b_q   <= tag_b_d;
      b_valid_q <= b_valid_d;
      flags_q   <= flags_d;
    end
  end

  assign out_valid  = b_valid_q;
  assign out_result = res_q;
  assign out_error  = err_q;
  assign out_tag    = tag_b_q;
  assign flags      = flags_q;
  assign busy       = a_valid_q || b_valid_q;

endmodule

// File: tb/tb_fp_addsub_issue.sv
// Directed bench for fp_addsub_issue: a queue-based reference of the pipeline
// (capacity 2, FIFO, one-edge minimum residency) checked every negedge.
module tb_fp_addsub_issue;

  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic             in_op = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_result;
  logic [2:0]       out_error;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       flags;
  logic             flags_clr = 1'b0;
  logic             busy;

  logic [31:0] exp_res_drv = '0;
  logic [2:0]  exp_err_drv = '0;

  int n_chk  = 0;
  int n_pass = 0;
  int edges  = 0;

  typedef struct {
    logic [31:0]      res;
    logic [2:0]       err;
    logic [TAG_W-1:0] tag;
    int               acc;
  } exp_t;

  exp_t       q[$];
  logic [2:0] m_flags = '0;

  fp_addsub_issue #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_error  (out_error),
    .out_tag    (out_tag),
    .flags      (flags),
    .flags_clr  (flags_clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, expv, $time);
  endtask

  // Reference: ops wait in order, at most two inside, each visible one edge after accept.
  always @(negedge clk) begin
    bit   mv, rdy, ret, acc;
    exp_t h, n;
    if (reset) begin
      chk("m_rst_out_valid", out_valid, 0);
      chk("m_rst_flags", flags, 0);
      chk("m_rst_busy", busy, 0);
      q.delete();
      m_flags = '0;
    end else begin
      mv  = (q.size() != 0) && (q[0].acc < edges);
      rdy = (q.size() < 2) || out_ready;
      chk("m_out_valid", out_valid, mv);
      chk("m_in_ready", in_ready, rdy);
      chk("m_busy", busy, q.size() != 0);
      chk("m_flags", flags, m_flags);
      if (mv) begin
        h = q[0];
        chk("m_result", out_result, h.res);
        chk("m_error", out_error, h.err);
        chk("m_tag", out_tag, h.tag);
      end
      ret = mv && out_ready;
      acc = in_valid && rdy;
      if (flags_clr) m_flags = ret ? h.err : 3'b000;
      else if (ret) m_flags = m_flags | h.err;
      if (ret) void'(q.pop_front());
      if (acc) begin
        n.res = exp_res_drv;
        n.err = exp_err_drv;
        n.tag = in_tag;
        n.acc = edges + 1;
        q.push_back(n);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                      input logic [TAG_W-1:0] tag, input logic [31:0] r, input logic [2:0] e);
    bit took;
    int guard;
    guard = 0;
    in_a = a; in_b = b; in_op = op; in_tag = tag;
    exp_res_drv = r; exp_err_drv = e;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      guard++;
    end while (!took && guard < 50);
    chk("send_accept", took, 1);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_idle", busy, 0);
  endtask

  task automatic pulse_clr();
    flags_clr = 1'b1;
    @(posedge clk);
    #1 flags_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout at t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_error", out_error, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_flags", flags, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single add 1.0 + 2.0, tag 5.
    send(32'h3F800000, 32'h40000000, 1'b0, 4'd5, 32'h40400000, 3'b000);
    @(negedge clk);
    chk("lat_not_yet", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("single_result", out_result, 32'h40400000);
    chk("single_tag", out_tag, 5);
    chk("single_error", out_error, 0);
    drain();

    // Back-to-back: 3.0-1.0 then 1.5+1.5.
    send(32'h40400000, 32'h3F800000, 1'b1, 4'd1, 32'h40000000, 3'b000);
    send(32'h3FC00000, 32'h3FC00000, 1'b0, 4'd2, 32'h40400000, 3'b000);
    @(negedge clk);
    chk("b2b_first", out_result, 32'h40000000);
    @(negedge clk);
    chk("b2b_second_valid", out_valid, 1);
    chk("b2b_second", out_result, 32'h40400000);
    drain();

    // Backpressure with rounding cases: tie-to-even stays, above-tie rounds up.
    out_ready = 1'b0;
    send(32'h3F800000, 32'h33800000, 1'b0, 4'd3, 32'h3F800000, 3'b000);
    send(32'h3F800000, 32'h33800001, 1'b0, 4'd4, 32'h3F800001, 3'b000);
    in_a = 32'hBF800000; in_b = 32'hC0000000; in_op = 1'b0; in_tag = 4'd6;
    exp_res_drv = 32'hC0400000; exp_err_drv = 3'b000;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_hold_result", out_result, 32'h3F800000);
      chk("bp_hold_tag", out_tag, 3);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second", out_result, 32'h3F800001);
    @(negedge clk);
    chk("bp_third", out_result, 32'hC0400000);
    chk("bp_third_tag", out_tag, 6);
    @(posedge clk);
    #1;
    drain();

    // Sticky flags.
    pulse_clr();
    chk("flags_cleared", flags, 0);
    send(32'h7FC00000, 32'h3F800000, 1'b0, 4'd7, 32'h7FC00000, 3'b001);
    drain();
    chk("flags_nan", flags, 3'b001);
    send(32'h3F800000, 32'h3F800000, 1'b1, 4'd8, 32'h00000000, 3'b000);
    drain();
    chk("flags_after_clean", flags, 3'b001);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd9, 32'h7F800000, 3'b010);
    drain();
    chk("flags_overflow", flags, 3'b011);
    send(32'h7FC00000, 32'h3F800000, 1'b0, 4'd10, 32'h7FC00000, 3'b001);
    @(posedge clk);
    #1 pulse_clr();
    chk("flags_clr_with_retire", flags, 3'b001);
    drain();
    send(32'h00800001, 32'h00800000, 1'b1, 4'd11, 32'h00000000, 3'b100);
    drain();
    chk("flags_underflow", flags, 3'b101);
    send(32'h7F800000, 32'h7F800000, 1'b1, 4'd12, 32'h7FC00000, 3'b001);
    drain();
    chk("flags_inf_minus_inf", flags, 3'b101);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 1'b0, 4'd1, 32'h40400000, 3'b000);
    send(32'h40000000, 32'h40000000, 1'b0, 4'd2, 32'h40800000, 3'b000);
    chk("pre_reset_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_flags", flags, 0);
    chk("async_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_result", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(32'h40400000, 32'h3F800000, 1'b0, 4'd13, 32'h40800000, 3'b000);
    @(negedge clk);
    chk("post_rst_lat_early", out_valid, 0);
    @(negedge clk);
    chk("post_rst_lat_valid", out_valid, 1);
    chk("post_rst_result", out_result, 32'h40800000);
    chk("post_rst_tag", out_tag, 13);
    @(posedge clk);
    #1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
